// File: rtl/aes_inv_key_stream_if.sv
// AES inverse key stream bus.
// Start/key request plus valid/ready round-key stream.
interface aes_inv_key_stream_if;
  logic         start;
  logic [255:0] key;
  logic [1:0]   Algorithm;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         rk_last;
  logic         done;

  modport master (
    output start, key, Algorithm, rk_ready,
    input  busy, rk_valid, rk_out, rk_idx,
    input  rk_last, done
  );

  modport slave (
    input  start, key, Algorithm, rk_ready,
    output busy, rk_valid, rk_out, rk_idx,
    output rk_last, done
  );
endinterface

// File: rtl/aes_inv_key_stream.sv
// AES key expansion into a word buffer, then
// round keys streamed out in decryption order.
module aes_inv_key_stream (
  input  logic                 clk,
  input  logic                 rst_n,
  aes_inv_key_stream_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE, EXPAND, STREAM
  } state_t;

  state_t      st, st_nx;
  logic [1:0]  alg, a_in;
  logic [31:0] w [60];
  logic [5:0]  wi, nk, wlast;
  logic [2:0]  wj, jlast;
  logic [7:0]  rc;
  logic [3:0]  ri, nr;
  logic        dn, vld, go, xfer, fin, wend;
  logic [31:0] tmp, old, rot, t, nw;

  function automatic logic [5:0] nk_of(
    input logic [1:0] a
  );
    unique case (a)
      2'd1:    return 6'd6;
      2'd2:    return 6'd8;
      default: return 6'd4;
    endcase
  endfunction

  function automatic logic [7:0] xt(
    input logic [7:0] a
  );
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Field inverse as x^254, then the affine map.
  function automatic logic [7:0] sbox(
    input logic [7:0] a
  );
    logic [7:0] r, x;
    r = 8'h01;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (k != 0) r = gmul(r, x);
      x = gmul(x, x);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
         ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]}
         ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(
    input logic [31:0] a
  );
    return {sbox(a[31:24]), sbox(a[23:16]),
            sbox(a[15:8]),  sbox(a[7:0])};
  endfunction

  // Key-size dependent limits from the latched algorithm.
  always_comb begin
    nk    = 6'd4;
    nr    = 4'd10;
    wlast = 6'd43;
    unique case (alg)
      2'd1: begin
        nk = 6'd6; nr = 4'd12; wlast = 6'd51;
      end
      2'd2: begin
        nk = 6'd8; nr = 4'd14; wlast = 6'd59;
      end
      default: ;
    endcase
    jlast = 3'(nk - 6'd1);
  end

  assign a_in = (bus.Algorithm == 2'b11)
              ? 2'b00 : bus.Algorithm;
  assign vld  = (st == STREAM);
  assign go   = (st == IDLE) && bus.start;
  assign xfer = vld && bus.rk_ready;
  assign fin  = xfer && (ri == 4'd0);
  assign wend = (st == EXPAND) && (wi == wlast);

  // Next expanded word; wj tracks i mod Nk.
  always_comb begin
    tmp = w[wi - 6'd1];
    old = w[wi - nk];
    rot = {tmp[23:0], tmp[31:24]};
    t   = tmp;
    unique case (1'b1)
      (wj == 3'd0):
        t = subw(rot) ^ {rc, 24'h0};
      (nk == 6'd8 && wj == 3'd4):
        t = subw(tmp);
      default: t = tmp;
    endcase
    nw = old ^ t;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nx;
  end

  // Next-state logic.
  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE:    if (bus.start) st_nx = EXPAND;
      EXPAND:  if (wend)      st_nx = STREAM;
      STREAM:  if (fin)       st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  // Expansion counters, rcon and stream index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alg <= 2'd0;
      wi  <= 6'd0;
      wj  <= 3'd0;
      rc  <= 8'h01;
      ri  <= 4'd0;
      dn  <= 1'b0;
    end else begin
      dn <= fin;
      if (go) begin
        alg <= a_in;
        wi  <= nk_of(a_in);
        wj  <= 3'd0;
        rc  <= 8'h01;
      end
      if (st == EXPAND) begin
        wi <= wi + 6'd1;
        wj <= (wj == jlast) ? 3'd0 : wj + 3'd1;
        if (wj == 3'd0) rc <= xt(rc);
        if (wend) ri <= nr;
      end
      if (xfer) ri <= ri - 4'd1;
    end
  end

  // Word buffer: key load on start, one word per EXPAND cycle.
  always_ff @(posedge clk) begin
    if (go) begin
      w[0] <= bus.key[255:224];
      w[1] <= bus.key[223:192];
      w[2] <= bus.key[191:160];
      w[3] <= bus.key[159:128];
      w[4] <= bus.key[127:96];
      w[5] <= bus.key[95:64];
      w[6] <= bus.key[63:32];
      w[7] <= bus.key[31:0];
    end else if (st == EXPAND) begin
      w[wi] <= nw;
    end
  end

  // Outputs, zeroed whenever no key is offered.
  always_comb begin
    bus.busy     = (st != IDLE);
    bus.rk_valid = vld;
    bus.done     = dn;
    bus.rk_idx   = vld ? ri : 4'd0;
    bus.rk_last  = vld && (ri == 4'd0);
    bus.rk_out   = vld ? {w[{ri, 2'd0}], w[{ri, 2'd1}],
                          w[{ri, 2'd2}], w[{ri, 2'd3}]}
                       : 128'd0;
  end
endmodule

// File: tb/tb_aes_inv_key_stream.sv
// Bench for aes_inv_key_stream: known vectors,
// random keys/stalls, reset abort, ignored starts.
module tb_aes_inv_key_stream;
  logic clk = 1'b0;
  logic rst_n;

  aes_inv_key_stream_if bus ();

  aes_inv_key_stream dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   alg;
    logic [255:0] key;
    int           nr;
    logic [127:0] first;
    logic [127:0] last;
  } vec_t;

  int npass = 0;
  int ntot  = 0;
  logic [7:0]   sb [256];
  logic [7:0]   rcon [11];
  logic [127:0] ref_rk [15];

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h",
                  nm, act, exp);
  endtask

  function automatic logic [7:0] rl(
    input logic [7:0] q, input int n);
    logic [15:0] d;
    d = {q, q} << n;
    return d[15:8];
  endfunction

  // S-box from the 3 / 3^-1 generator walk.
  task automatic mk_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [31:0] sw(
    input logic [31:0] a);
    return {sb[a[31:24]], sb[a[23:16]],
            sb[a[15:8]],  sb[a[7:0]]};
  endfunction

  function automatic int nk_of(input logic [1:0] a);
    return (a == 2'd1) ? 6 : (a == 2'd2) ? 8 : 4;
  endfunction

  // FIPS-197 expansion into the reference key list.
  task automatic build(input logic [1:0] a,
                       input logic [255:0] k);
    int nk, nr;
    logic [31:0] w [60];
    logic [31:0] t;
    nk = nk_of(a);
    nr = nk + 6;
    for (int i = 0; i < nk; i++)
      w[i] = k[255 - 32 * i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i - 1];
      if (i % nk == 0)
        t = sw({t[23:0], t[31:24]})
          ^ {rcon[i / nk], 24'h0};
      else if (nk == 8 && i % 8 == 4)
        t = sw(t);
      w[i] = w[i - nk] ^ t;
    end
    for (int r = 0; r <= nr; r++)
      ref_rk[r] = {w[4 * r], w[4 * r + 1],
                   w[4 * r + 2], w[4 * r + 3]};
  endtask

  function automatic logic [255:0] rkey();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32 * i +: 32] = $urandom;
    return k;
  endfunction

  // Start at the current negedge; returns edges to rk_valid.
  task automatic kick(input logic [1:0] a,
                      input logic [255:0] k,
                      output int lat);
    bus.Algorithm = a;
    bus.key       = k;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.key       = rkey();
    bus.Algorithm = 2'($urandom_range(3));
    lat = 0;
    while (!bus.rk_valid && lat < 200) begin
      if (lat == 3)
        chk("busy_expand", 128'(bus.busy), 128'd1);
      if (lat == 5) begin
        bus.start = 1'b1;
        bus.key   = rkey();
      end
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
    end
  endtask

  task automatic zeros(input string nm);
    chk({nm, "_valid"}, 128'(bus.rk_valid), 128'd0);
    chk({nm, "_busy"},  128'(bus.busy),     128'd0);
    chk({nm, "_out"},   bus.rk_out,         128'd0);
    chk({nm, "_idx"},   128'(bus.rk_idx),   128'd0);
    chk({nm, "_last"},  128'(bus.rk_last),  128'd0);
  endtask

  // Consume the stream; ends on the done cycle.
  task automatic stream(input int nr, input int pct,
                        input int abort_after);
    int r, cyc;
    r = nr;
    cyc = 0;
    while (r >= 0 && cyc < 3000) begin
      if (abort_after >= 0 && nr - r == abort_after) begin
        rst_n = 1'b0;
        #1;
        zeros("rst_async");
        chk("rst_async_done", 128'(bus.done), 128'd0);
        bus.rk_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      chk("rk_valid", 128'(bus.rk_valid), 128'd1);
      chk("rk_idx",   128'(bus.rk_idx),   128'(r));
      chk("rk_out",   bus.rk_out,         ref_rk[r]);
      chk("rk_last",  128'(bus.rk_last),  128'(r == 0));
      chk("done_early", 128'(bus.done),   128'd0);
      bus.rk_ready = ($urandom_range(99) < pct);
      if (bus.rk_ready) r--;
      @(negedge clk);
      cyc++;
    end
    bus.rk_ready = 1'b0;
    chk("stream_timeout", 128'(cyc < 3000), 128'd1);
    chk("done_pulse", 128'(bus.done), 128'd1);
    zeros("after_last");
  endtask

  vec_t tv [4];
  int lat, g;
  logic [1:0] a;
  logic [255:0] k;

  initial begin
    tv[0] = '{2'd0, {128'h000102030405060708090a0b0c0d0e0f,
              128'h0}, 10,
              128'h13111d7fe3944a17f307a78b4d2b30c5,
              128'h000102030405060708090a0b0c0d0e0f};
    tv[1] = '{2'd1,
              {192'h000102030405060708090a0b0c0d0e0f1011121314151617,
              64'h0}, 12,
              128'ha4970a331a78dc09c418c271e3a41d5d,
              128'h000102030405060708090a0b0c0d0e0f};
    tv[2] = '{2'd2,
              256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
              14,
              128'h24fc79ccbf0979e9371ac23c6d68de36,
              128'h000102030405060708090a0b0c0d0e0f};
    tv[3] = '{2'd3, {128'h000102030405060708090a0b0c0d0e0f,
              128'h0}, 10,
              128'h13111d7fe3944a17f307a78b4d2b30c5,
              128'h000102030405060708090a0b0c0d0e0f};
    rcon = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
             8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    mk_sbox();

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.key = '0;
    bus.Algorithm = 2'd0;
    bus.rk_ready = 1'b0;
    repeat (3) @(negedge clk);
    zeros("reset");
    chk("reset_done", 128'(bus.done), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      build(tv[v].alg, tv[v].key);
      chk("model_first", ref_rk[tv[v].nr], tv[v].first);
      chk("model_last", ref_rk[0], tv[v].last);
      kick(tv[v].alg, tv[v].key, lat);
      g = 3 * nk_of(tv[v].alg) + 28;
      chk("latency", 128'(lat), 128'(g));
      chk("vec_first", bus.rk_out, tv[v].first);
      stream(tv[v].nr, 100, -1);
      @(negedge clk);
      chk("done_width", 128'(bus.done), 128'd0);
    end

    build(tv[0].alg, tv[0].key);
    kick(tv[0].alg, tv[0].key, lat);
    stream(10, 30, -1);
    @(negedge clk);
    chk("stall_done_width", 128'(bus.done), 128'd0);

    a = 2'($urandom_range(3));
    k = rkey();
    build(a, k);
    kick(a, k, lat);
    stream(nk_of(a) + 6, 100, -1);
    a = 2'($urandom_range(3));
    k = rkey();
    build(a, k);
    kick(a, k, lat);
    chk("done_cycle_start_lat", 128'(lat),
        128'(3 * nk_of(a) + 28));
    stream(nk_of(a) + 6, 70, -1);
    @(negedge clk);

    build(tv[0].alg, tv[0].key);
    kick(tv[0].alg, tv[0].key, lat);
    stream(10, 100, 2);
    for (int i = 0; i < 4; i++) begin
      zeros("post_abort");
      chk("post_abort_done", 128'(bus.done), 128'd0);
      bus.rk_ready = 1'b1;
      @(negedge clk);
    end
    bus.rk_ready = 1'b0;
    build(tv[2].alg, tv[2].key);
    kick(tv[2].alg, tv[2].key, lat);
    chk("restart_lat", 128'(lat), 128'd52);
    chk("restart_first", bus.rk_out, tv[2].first);
    stream(14, 100, -1);
    @(negedge clk);

    for (int n = 0; n < 6; n++) begin
      a = 2'($urandom_range(3));
      k = rkey();
      build(a, k);
      kick(a, k, lat);
      chk("rand_lat", 128'(lat), 128'(3 * nk_of(a) + 28));
      stream(nk_of(a) + 6, 30 + 14 * n, -1);
      @(negedge clk);
      chk("rand_done_width", 128'(bus.done), 128'd0);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/aes_inv_key_stream.md
AES_INV_KEY_STREAM -- requirements
Module: aes_inv_key_stream

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have port start, input, 1 bit: request expansion; sampled only in IDLE.
REQ-004 The block SHALL have port key, input, 256 bits: cipher key, left-justified; unused low bits are don't-care.
REQ-005 The block SHALL have port Algorithm, input, 2 bits: 00=AES-128, 01=AES-192, 10=AES-256, 11 treated as 00.
REQ-006 The block SHALL have port busy, output, 1 bit: high in EXPAND and STREAM.
REQ-007 The block SHALL have port rk_valid, output, 1 bit: rk_out/rk_idx/rk_last hold a valid round key.
REQ-008 The block SHALL have port rk_ready, input, 1 bit: consumer accepts; transfer = rk_valid & rk_ready.
REQ-009 The block SHALL have port rk_out, output, 128 bits: round key, w[4r] in bits 127:96.
REQ-010 The block SHALL have port rk_idx, output, 4 bits: round number r of rk_out.
REQ-011 The block SHALL have port rk_last, output, 1 bit: high with rk_valid when rk_idx=0.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse after final transfer.

Function
REQ-013 The block SHALL implement states IDLE, EXPAND, STREAM; IDLE->EXPAND on start; EXPAND->STREAM on last word written; STREAM->IDLE on rk_idx=0 transfer.
REQ-014 On start in IDLE the block SHALL latch Algorithm and load key words w[0..Nk-1] from key[255:256-32*Nk] in the same edge; Nk/Nr = 4/10, 6/12, 8/14.
REQ-015 In EXPAND the block SHALL write exactly one word per cycle for i=Nk..4*Nr+3 (G = 40/46/52 cycles) into an internal 60x32 word buffer.
REQ-016 Word rule SHALL be FIPS-197: temp=w[i-1]; i mod Nk=0 -> SubWord(RotWord(temp)) xor Rcon[i/Nk]; Nk=8 and i mod 8=4 -> SubWord(temp); w[i]=w[i-Nk] xor temp.
REQ-017 Rcon SHALL be 01,02,04,08,10,20,40,80,1b,36 in the top byte, zero below.
REQ-018 rk_valid SHALL rise exactly G edges after the edge that sampled start, with rk_idx=Nr.
REQ-019 STREAM SHALL present round keys in descending order Nr..0, rk_idx decrementing by 1 per transfer.
REQ-020 While rk_valid & !rk_ready, rk_out, rk_idx, rk_last SHALL hold stable; rk_valid SHALL NOT drop before transfer.
REQ-021 Back-to-back transfers SHALL be supported: one round key per cycle with rk_ready held high.
REQ-022 After the rk_idx=0 transfer: rk_valid low, busy low, done high for exactly one cycle, state IDLE.
REQ-023 start while busy SHALL be ignored; key/Algorithm changes after the start edge SHALL have no effect.
REQ-024 start asserted in the done cycle SHALL be accepted (state is IDLE).
REQ-025 rk_out SHALL be 0 and rk_idx 0 whenever rk_valid is low.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, busy=0, rk_valid=0, rk_last=0, done=0, rk_out=0, rk_idx=0, regardless of edge.
REQ-027 Reset mid-EXPAND or mid-STREAM SHALL abort; no round key or done pulse appears until a new start.
REQ-028 Word buffer contents need not be cleared by reset.

Verification
REQ-029 AES-128 key 000102..0f, Alg=00, ready=1 -> valid after 40 cycles, first rk_idx=10 rk_out=13111d7fe3944a17f307a78b4d2b30c5, last rk_idx=0 rk_out=000102030405060708090a0b0c0d0e0f, rk_last, done pulse.
REQ-030 AES-192 key 000102..17 left-justified, Alg=01 -> valid after 46 cycles, rk_idx=12 rk_out=a4970a331a78dc09c418c271e3a41d5d, 13 transfers total.
REQ-031 AES-256 key 000102..1f, Alg=10 -> valid after 52 cycles, rk_idx=14 rk_out=24fc79ccbf0979e9371ac23c6d68de36, 15 transfers.
REQ-032 AES-128 with rk_ready random 30% -> outputs stable during stalls, same 11 keys in order, single done pulse.
REQ-033 rst_n low at 3rd STREAM transfer, then new start with AES-256 -> outputs zero immediately, fresh stream from rk_idx=14 correct.
REQ-034 start pulsed during EXPAND with different key -> ignored; stream matches original key.
